// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back path.
package regfile_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int WB_DATA_W  = 32;

    // Which source owns the register-file write port in a given cycle.
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2
    } wb_src_t;

    // One register-file write request (destination plus data).
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]  data;
    } wb_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with valid/ready push side and a plain pop strobe.
// push_ready comes from the registered count only, so a full FIFO never
// accepts a push even in a cycle where it is also popped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty      = (count == '0);
    assign push_ready = (count != CW'(DEPTH));
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop && !empty;
    assign pop_data   = mem[rd_ptr];

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-back initiator: merges ALU results and buffered load
// returns onto the single write port, and tracks pending loads so the issue
// stage can detect operand hazards.
module regfile_writeback
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]     alu_data,
    output logic                  alu_stall,

    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]     mem_data,

    input  logic                  ld_issue,
    input  logic [REG_ADDR_W-1:0] ld_rd,

    input  logic [REG_ADDR_W-1:0] q_rs,
    input  logic [REG_ADDR_W-1:0] q_rt,
    input  logic [REG_ADDR_W-1:0] q_rd,
    output logic                  hazard,

    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0]     rf_wd
);

    localparam int ENTRY_W = REG_ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    logic                  fifo_push_ready;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [CNT_W-1:0]      fifo_count;
    logic [ENTRY_W-1:0]    fifo_head;

    wb_src_t               sel_src;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0]     sel_data;

    wb_src_t               rf_src;
    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_nxt;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_load_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (mem_valid),
        .push_ready (fifo_push_ready),
        .push_data  ({mem_rd, mem_data}),
        .pop        (fifo_pop),
        .pop_data   (fifo_head),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign mem_ready = fifo_push_ready;
    assign alu_stall = (fifo_count == CNT_W'(FIFO_DEPTH));

    // Write-port arbitration: the ALU always wins, otherwise drain the load buffer head.
    always_comb begin
        sel_src  = WB_NONE;
        sel_rd   = '0;
        sel_data = '0;
        fifo_pop = 1'b0;
        if (alu_valid) begin
            sel_src  = WB_ALU;
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end else if (!fifo_empty) begin
            sel_src            = WB_MEM;
            {sel_rd, sel_data} = fifo_head;
            fifo_pop           = 1'b1;
        end
    end

    // Register the selected write; r0 is hard-wired zero so its writes are consumed but never enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we  <= 1'b0;
            rf_rd  <= '0;
            rf_wd  <= '0;
            rf_src <= WB_NONE;
        end else begin
            rf_we  <= (sel_src != WB_NONE) && (sel_rd != '0);
            rf_src <= sel_src;
            if (sel_src != WB_NONE) begin
                rf_rd <= sel_rd;
                rf_wd <= sel_data;
            end
        end
    end

    // Next pending vector: a retiring load clears its bit, a new issue sets it and wins a collision.
    always_comb begin
        pending_nxt = pending;
        if (rf_we && (rf_src == WB_MEM)) begin
            pending_nxt[rf_rd] = 1'b0;
        end
        if (ld_issue && (ld_rd != '0)) begin
            pending_nxt[ld_rd] = 1'b1;
        end
    end

    // Pending-load scoreboard; clearing on the retiring write's edge makes hazard drop
    // exactly when the register file holds the loaded value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign hazard = pending[q_rs] | pending[q_rt] | pending[q_rd];

    // The execute stage must not present a result while the load buffer is full.
    a_no_alu_when_stalled : assert property (
        @(posedge clk) disable iff (!rst_n) !(alu_valid && alu_stall)
    );

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios with literal
// expectations plus a randomized run against a queue-based reference model.
module tb_regfile_writeback;
    import regfile_wb_pkg::*;

    localparam int DW = 32;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [DW-1:0] alu_data;
    logic          alu_stall;
    logic          mem_valid;
    logic          mem_ready;
    logic [4:0]    mem_rd;
    logic [DW-1:0] mem_data;
    logic          ld_issue;
    logic [4:0]    ld_rd;
    logic [4:0]    q_rs, q_rt, q_rd;
    logic          hazard;
    logic          rf_we;
    logic [4:0]    rf_rd;
    logic [DW-1:0] rf_wd;

    always #5 clk = ~clk;

    regfile_writeback #(.DATA_W(DW), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_stall (alu_stall),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .ld_issue  (ld_issue),
        .ld_rd     (ld_rd),
        .q_rs      (q_rs),
        .q_rt      (q_rt),
        .q_rd      (q_rd),
        .hazard    (hazard),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wd     (rf_wd)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: load buffer as a queue, pending loads as a bit per register,
    // and the write that must appear on the port in the current cycle.
    wb_req_t       exp_q[$];
    bit            exp_pend[32];
    bit            exp_we;
    bit            exp_mem;
    bit [4:0]      exp_rd;
    bit [DW-1:0]   exp_wd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int r = 0; r < 32; r++) exp_pend[r] = 1'b0;
        exp_we  = 1'b0;
        exp_mem = 1'b0;
        exp_rd  = '0;
        exp_wd  = '0;
    endtask

    // Advance the model by one clock using the inputs held during the cycle just ended.
    task automatic model_step();
        bit          can_accept;
        bit          wv;
        bit          wmem;
        wb_req_t     w;
        wb_req_t     e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        can_accept = (exp_q.size() < FD);
        wv   = 1'b0;
        wmem = 1'b0;
        w    = '0;
        if (alu_valid) begin
            wv     = 1'b1;
            w.rd   = alu_rd;
            w.data = alu_data;
        end else if (exp_q.size() > 0) begin
            w    = exp_q.pop_front();
            wv   = 1'b1;
            wmem = 1'b1;
        end
        if (mem_valid && can_accept) begin
            e.rd   = mem_rd;
            e.data = mem_data;
            exp_q.push_back(e);
        end
        if (exp_we && exp_mem) exp_pend[exp_rd] = 1'b0;
        if (ld_issue && ld_rd != 0) exp_pend[ld_rd] = 1'b1;
        exp_we  = wv && (w.rd != 0);
        exp_mem = wmem;
        if (wv) begin
            exp_rd = w.rd;
            exp_wd = w.data;
        end
    endtask

    task automatic check_model();
        chk("rf_we", rf_we, exp_we);
        if (exp_we) begin
            chk("rf_rd", rf_rd, exp_rd);
            chk("rf_wd", rf_wd, exp_wd);
        end
        chk("mem_ready", mem_ready, exp_q.size() < FD);
        chk("alu_stall", alu_stall, exp_q.size() == FD);
        chk("hazard", hazard, exp_pend[q_rs] | exp_pend[q_rt] | exp_pend[q_rd]);
    endtask

    task automatic drive_idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        ld_issue  = 1'b0; ld_rd = '0;
        q_rs = '0; q_rt = '0; q_rd = '0;
    endtask

    // One cycle: compare against the model, clock, update the model; returns just after the edge.
    task automatic step();
        #1;
        check_model();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 1000000", $time);
        $fatal(1);
    end

    initial begin
        int      seen;
        bit      acc;
        bit [4:0]  seen_rd[8];
        bit [31:0] seen_wd[8];

        drive_idle();
        model_reset();

        // Reset held with inputs toggling.
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_data = $urandom;
            mem_valid = 1'($urandom); mem_rd = 5'($urandom); mem_data = $urandom;
            ld_issue  = 1'($urandom); ld_rd = 5'($urandom);
            @(posedge clk);
            #1;
            q_rs = 5'($urandom); q_rt = 5'($urandom); q_rd = 5'($urandom);
            #1;
            chk("reset_rf_we", rf_we, 0);
            chk("reset_rf_rd", rf_rd, 0);
            chk("reset_rf_wd", rf_wd, 0);
            chk("reset_mem_ready", mem_ready, 1);
            chk("reset_alu_stall", alu_stall, 0);
            chk("reset_hazard", hazard, 0);
        end
        drive_idle();
        rst_n = 1'b1;

        // ALU write: visible for exactly one cycle after issue.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        drive_idle();
        chk("alu_we", rf_we, 1);
        chk("alu_rd", rf_rd, 5);
        chk("alu_wd", rf_wd, 32'hDEADBEEF);
        step();
        chk("alu_we_once", rf_we, 0);

        // Load path with scoreboard.
        ld_issue = 1'b1; ld_rd = 5'd7;
        step();
        drive_idle();
        q_rs = 5'd7;
        #1 chk("ld_hazard_set", hazard, 1);
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1234;
        step();
        drive_idle(); q_rs = 5'd7;
        step();
        chk("ld_we_n2", rf_we, 1);
        chk("ld_rd_n2", rf_rd, 7);
        chk("ld_wd_n2", rf_wd, 32'h1234);
        #1 chk("ld_hazard_n2", hazard, 1);
        step();
        chk("ld_we_n3", rf_we, 0);
        #1 chk("ld_hazard_n3", hazard, 0);

        // Contention: ALU busy while loads arrive until the buffer fills.
        for (int i = 0; i < 4; i++) begin
            drive_idle();
            alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = $urandom;
            mem_valid = 1'b1; mem_rd = 5'(11 + i); mem_data = 32'h100 + 32'(i);
            step();
        end
        drive_idle();
        chk("cont_alu_stall", alu_stall, 1);
        chk("cont_mem_ready", mem_ready, 0);
        mem_valid = 1'b1; mem_rd = 5'd15; mem_data = 32'h104;
        seen = 0;
        for (int c = 0; c < 20 && seen < 5; c++) begin
            acc = (exp_q.size() < FD) && mem_valid;
            step();
            if (acc) begin
                mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
            end
            if (rf_we === 1'b1) begin
                seen_rd[seen] = rf_rd;
                seen_wd[seen] = rf_wd;
                seen++;
            end
        end
        chk("cont_retired", seen, 5);
        for (int i = 0; i < seen && i < 5; i++) begin
            chk("cont_order_rd", seen_rd[i], 11 + i);
            chk("cont_order_wd", seen_wd[i], 32'h100 + i);
        end
        drive_idle();

        // r0 suppression: writes consumed but never enabled, buffer still drains.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h55;
        step();
        drive_idle();
        chk("r0_alu_we", rf_we, 0);
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h77;
        step();
        drive_idle();
        chk("r0_ld_we", rf_we, 0);
        step();
        chk("r0_drain_we", rf_we, 1);
        chk("r0_drain_rd", rf_rd, 3);
        ld_issue = 1'b1; ld_rd = 5'd0;
        step();
        drive_idle();
        #1 chk("r0_no_hazard", hazard, 0);

        // Set/clear collision on r9.
        ld_issue = 1'b1; ld_rd = 5'd9;
        step();
        drive_idle();
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'hAAAA; q_rs = 5'd9;
        step();
        drive_idle(); q_rs = 5'd9;
        step();
        chk("coll_retire_rd", rf_rd, 9);
        ld_issue = 1'b1; ld_rd = 5'd9; q_rs = 5'd9;
        step();
        drive_idle(); q_rs = 5'd9;
        #1 chk("coll_set_wins", hazard, 1);
        step();
        step();
        chk("coll_still_pending", hazard, 1);
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'hBBBB; q_rs = 5'd9;
        step();
        drive_idle(); q_rs = 5'd9;
        step();
        chk("coll_second_wd", rf_wd, 32'hBBBB);
        step();
        #1 chk("coll_cleared", hazard, 0);

        // Reset in the middle of activity.
        drive_idle();
        ld_issue = 1'b1; ld_rd = 5'd10;
        mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'h1;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2;
        step();
        mem_rd = 5'd4; ld_issue = 1'b0; alu_rd = 5'd6;
        step();
        drive_idle();
        q_rs = 5'd10;
        chk("mid_pre_we", rf_we, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", rf_we, 0);
        chk("mid_rst_hazard", hazard, 0);
        chk("mid_rst_mem_ready", mem_ready, 1);
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        step();

        // Randomized traffic; alternate phases of light and heavy ALU load.
        for (int c = 0; c < 3000; c++) begin
            drive_idle();
            if (exp_q.size() < FD) begin
                if (((c / 200) % 2) == 1) alu_valid = ($urandom_range(0, 9) < 8);
                else                      alu_valid = ($urandom_range(0, 2) == 0);
            end
            alu_rd    = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
            mem_valid = 1'($urandom_range(0, 1));
            mem_rd    = 5'($urandom_range(0, 7));
            mem_data  = $urandom;
            ld_issue  = ($urandom_range(0, 3) == 0);
            ld_rd     = 5'($urandom_range(0, 7));
            q_rs      = 5'($urandom_range(0, 7));
            q_rt      = 5'($urandom_range(0, 7));
            q_rd      = 5'($urandom_range(0, 7));
            step();
        end
        drive_idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
